// File: rtl/fpga_button_reader.sv
`default_nettype none
// ============================================================================
// Module   : fpga_button_reader
// Brief    : Synchronises and debounces the board user button, classifies
//            presses as click / long press, and latches an active-low reboot
//            request on a long press.
// Revision : 1.0 - initial release
// ============================================================================
module fpga_button_reader #(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter int LONG_CYCLES     = 96000000,
    parameter int REBOOT_ON_LONG  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic reboot_req_n
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic              c_idle_lvl  = (ACTIVE_LOW != 0);
    localparam logic [DB_W-1:0]   c_db_last   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(LONG_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HELD = 2'd1;
    localparam logic [1:0] S_LONG = 2'd2;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_pressed;
    logic [DB_W-1:0]   r_db_cnt;
    logic [1:0]        r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_press_pulse;
    logic              r_release_pulse;
    logic              r_click_pulse;
    logic              r_long_pulse;

    logic              w_act;
    logic              w_differ;
    logic              w_accept;
    logic [1:0]        w_state_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_press_nxt;
    logic              w_release_nxt;
    logic              w_click_nxt;
    logic              w_long_nxt;

    // Two-flop synchroniser; resets to the idle pad level so no false press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= c_idle_lvl;
            r_sync2 <= c_idle_lvl;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_act    = r_sync2 ^ c_idle_lvl;
    assign w_differ = (w_act != r_pressed);
    // The edge on which the count would reach DEBOUNCE_CYCLES accepts the change.
    assign w_accept = w_differ && (r_db_cnt == c_db_last);

    // Debounce: count consecutive disagreeing cycles, toggle the level when enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_cnt  <= '0;
            r_pressed <= 1'b0;
        end else if (!w_differ) begin
            r_db_cnt  <= '0;
        end else if (w_accept) begin
            r_db_cnt  <= '0;
            r_pressed <= ~r_pressed;
        end else begin
            r_db_cnt  <= r_db_cnt + DB_W'(1);
        end
    end

    // Press classifier: next state, hold count and event pulses.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_click_nxt   = 1'b0;
        w_long_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_hold_nxt = '0;
                if (w_accept) begin
                    w_state_nxt = S_HELD;
                    w_press_nxt = 1'b1;
                end
            end
            S_HELD: begin
                // A release on the same edge as the long threshold wins.
                if (w_accept) begin
                    w_state_nxt   = S_IDLE;
                    w_hold_nxt    = '0;
                    w_release_nxt = 1'b1;
                    w_click_nxt   = 1'b1;
                end else if (r_hold_cnt == c_hold_last) begin
                    w_state_nxt = S_LONG;
                    w_hold_nxt  = r_hold_cnt + HOLD_W'(1);
                    w_long_nxt  = 1'b1;
                end else begin
                    w_hold_nxt  = r_hold_cnt + HOLD_W'(1);
                end
            end
            S_LONG: begin
                // Hold count parks at LONG_CYCLES so the long event cannot repeat.
                if (w_accept) begin
                    w_state_nxt   = S_IDLE;
                    w_hold_nxt    = '0;
                    w_release_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Classifier state, hold counter and registered event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_hold_cnt      <= '0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_click_pulse   <= 1'b0;
            r_long_pulse    <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_hold_cnt      <= w_hold_nxt;
            r_press_pulse   <= w_press_nxt;
            r_release_pulse <= w_release_nxt;
            r_click_pulse   <= w_click_nxt;
            r_long_pulse    <= w_long_nxt;
        end
    end

    generate
        if (REBOOT_ON_LONG != 0) begin : g_reboot_on
            logic r_reboot_n;
            // Sticky reboot request: falls with the long event, cleared only by reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_reboot_n <= 1'b1;
                end else if (w_long_nxt) begin
                    r_reboot_n <= 1'b0;
                end
            end
            assign reboot_req_n = r_reboot_n;
        end else begin : g_reboot_off
            assign reboot_req_n = 1'b1;
        end
    endgenerate

    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign click_pulse   = r_click_pulse;
    assign long_pulse    = r_long_pulse;

endmodule
`default_nettype wire

// File: tb/tb_fpga_button_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpga_button_reader
// Brief    : Self-checking bench for fpga_button_reader. Two instances share
//            stimulus (reboot on long enabled / disabled) and are compared
//            against a window-based reference model of the button rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpga_button_reader;

    localparam int AL = 1;
    localparam int DB = 4;
    localparam int LC = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_in = 1'b1;

    logic pressed, press_pulse, release_pulse, click_pulse, long_pulse, reboot_req_n;
    logic nr_pressed, nr_press, nr_release, nr_click, nr_long, nr_reboot_n;

    always #5 clk = ~clk;

    fpga_button_reader #(
        .ACTIVE_LOW(AL), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC), .REBOOT_ON_LONG(1)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .click_pulse(click_pulse), .long_pulse(long_pulse), .reboot_req_n(reboot_req_n)
    );

    fpga_button_reader #(
        .ACTIVE_LOW(AL), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC), .REBOOT_ON_LONG(0)
    ) dut_nr (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .pressed(nr_pressed), .press_pulse(nr_press), .release_pulse(nr_release),
        .click_pulse(nr_click), .long_pulse(nr_long), .reboot_req_n(nr_reboot_n)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_n = 0;

    // Reference model: act seen before edge n is the raw sample taken at edge n-2.
    bit samp [0:8191];
    bit m_pressed   = 1'b0;
    bit m_long_done = 1'b0;
    bit m_reboot    = 1'b1;
    int m_tog       = 0;
    int m_pedge     = 0;
    bit e_press = 1'b0, e_rel = 1'b0, e_click = 1'b0, e_long = 1'b0;

    logic [11:0] obs;
    logic [11:0] exp_v;
    assign obs   = {pressed, press_pulse, release_pulse, click_pulse, long_pulse, reboot_req_n,
                    nr_pressed, nr_press, nr_release, nr_click, nr_long, nr_reboot_n};
    assign exp_v = {m_pressed, e_press, e_rel, e_click, e_long, m_reboot,
                    m_pressed, e_press, e_rel, e_click, e_long, 1'b1};

    function automatic void model_edge(input bit b, input bit r);
        bit acc;
        int n;
        n = edge_n;
        e_press = 1'b0; e_rel = 1'b0; e_click = 1'b0; e_long = 1'b0;
        if (r) begin
            samp[n-1]   = 1'b0;
            samp[n]     = 1'b0;
            m_pressed   = 1'b0;
            m_tog       = n;
            m_pedge     = n;
            m_long_done = 1'b0;
            m_reboot    = 1'b1;
            return;
        end
        samp[n] = (b != (AL != 0));
        // Accept when the last DB seen levels all disagree and none predates the last toggle.
        acc = ((n - m_tog) >= DB);
        for (int i = 0; i < DB; i++)
            if ((n - 2 - i) < 0 || samp[n-2-i] == m_pressed) acc = 1'b0;
        e_press = acc && !m_pressed;
        e_rel   = acc && m_pressed;
        e_click = e_rel && !m_long_done;
        e_long  = m_pressed && !e_rel && !m_long_done && ((n - m_pedge) == LC);
        if (acc)     begin m_tog = n; m_pressed = !m_pressed; end
        if (e_press) begin m_pedge = n; m_long_done = 1'b0; end
        if (e_long)  begin m_long_done = 1'b1; m_reboot = 1'b0; end
    endfunction

    task automatic tick(input bit b, input bit r);
        btn_in = b;
        rst    = r;
        @(posedge clk);
        edge_n++;
        model_edge(b, r);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1);
            n_cmp++;
            if (obs !== 12'b000001_000001) begin
                n_fail++;
                $display("FAIL reset edge=%0d got=%b want=%b", edge_n, obs, 12'b000001_000001);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL reset_idle edge=%0d got=%b want=%b", edge_n, obs, exp_v);
            end
        end
    endtask

    task automatic test_click();
        int k, j, rise, rel, longs;
        rise = -1; rel = -1; longs = 0;
        k = edge_n + 1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL click_hold edge=%0d got=%b want=%b", edge_n, obs, exp_v);
            end
            if (press_pulse && pressed && rise < 0) rise = edge_n;
            if (long_pulse) longs++;
        end
        j = edge_n + 1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL click_release edge=%0d got=%b want=%b", edge_n, obs, exp_v);
            end
            if (release_pulse && click_pulse && rel < 0) rel = edge_n;
            if (long_pulse) longs++;
        end
        n_cmp++;
        if (rise !== k + 5) begin
            n_fail++;
            $display("FAIL click_press_edge got=%0d want=%0d", rise, k + 5);
        end
        n_cmp++;
        if (rel !== j + 5) begin
            n_fail++;
            $display("FAIL click_release_edge got=%0d want=%0d", rel, j + 5);
        end
        n_cmp++;
        if (longs !== 0) begin
            n_fail++;
            $display("FAIL click_no_long got=%0d want=0", longs);
        end
    endtask

    task automatic test_bounce();
        int bad;
        bad = 0;
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 6; i++) begin
                tick((i >= 3), 1'b0);
                n_cmp++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL bounce edge=%0d got=%b want=%b", edge_n, obs, exp_v);
                end
                if (pressed || press_pulse || release_pulse || click_pulse || long_pulse) bad++;
            end
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bounce_quiet got=%0d active cycles want=0", bad);
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    endtask

    task automatic test_long();
        int k, lng, fall, longs, clicks, rels;
        lng = -1; fall = -1; longs = 0; clicks = 0; rels = 0;
        k = edge_n + 1;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL long_hold edge=%0d got=%b want=%b", edge_n, obs, exp_v);
            end
            if (long_pulse) begin longs++; if (lng < 0) lng = edge_n; end
            if (!reboot_req_n && fall < 0) fall = edge_n;
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL long_release edge=%0d got=%b want=%b", edge_n, obs, exp_v);
            end
            if (click_pulse) clicks++;
            if (release_pulse) rels++;
        end
        n_cmp++;
        if (lng !== k + 5 + LC || longs !== 1) begin
            n_fail++;
            $display("FAIL long_edge got=%0d (count %0d) want=%0d (count 1)", lng, longs, k + 5 + LC);
        end
        n_cmp++;
        if (fall !== k + 5 + LC) begin
            n_fail++;
            $display("FAIL long_reboot_edge got=%0d want=%0d", fall, k + 5 + LC);
        end
        n_cmp++;
        if (rels !== 1 || clicks !== 0 || reboot_req_n !== 1'b0) begin
            n_fail++;
            $display("FAIL long_release_kind got rel=%0d click=%0d reboot_n=%b want rel=1 click=0 reboot_n=0",
                     rels, clicks, reboot_req_n);
        end
    endtask

    task automatic test_rst_mid_press();
        int k, p, r_edge, rise, lng;
        rise = -1; lng = -1;
        tick(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        k = edge_n + 1;
        p = k + 5;
        while (edge_n < p + 9) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        r_edge = edge_n;
        n_cmp++;
        if (obs !== 12'b000001_000001) begin
            n_fail++;
            $display("FAIL rst_mid_values got=%b want=%b", obs, 12'b000001_000001);
        end
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rst_mid_hold edge=%0d got=%b want=%b", edge_n, obs, exp_v);
            end
            if (pressed && rise < 0) rise = edge_n;
            if (long_pulse && lng < 0) lng = edge_n;
        end
        n_cmp++;
        if (rise !== r_edge + 6) begin
            n_fail++;
            $display("FAIL rst_mid_rerise got=%0d want=%0d", rise, r_edge + 6);
        end
        n_cmp++;
        if (lng !== r_edge + 6 + LC) begin
            n_fail++;
            $display("FAIL rst_mid_long got=%0d want=%0d", lng, r_edge + 6 + LC);
        end
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    endtask

    task automatic test_random();
        int left;
        bit lvl;
        left = 0;
        lvl  = 1'b1;
        for (int c = 0; c < 600; c++) begin
            if (left == 0) begin
                lvl  = !lvl;
                left = $urandom_range(1, 30);
            end
            tick(lvl, ($urandom_range(0, 79) == 0));
            left--;
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random edge=%0d got=%b want=%b", edge_n, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_click();
        test_bounce();
        test_long();
        test_rst_mid_press();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpga_button_reader.md
# fpga_button_reader

Input-side conditioner for the board user button on the FPGA top level. It synchronises and debounces the raw pad, then classifies each press as a click or a long press, emitting single-cycle event pulses. A long press can optionally latch an active-low reboot request, which the board top drives onto the reconfiguration/bootloader pin. It replaces direct sampling of the raw pad, so a bounce or a tap cannot drop the board into the bootloader.

## Interface
Parameters:
- `ACTIVE_LOW`, default 1: raw pad polarity; 1 means the pad reads 0 while pressed.
- `DEBOUNCE_CYCLES`, default 48000: consecutive stable cycles required to accept a level change (1 ms at 48 MHz). Must be ≥1.
- `LONG_CYCLES`, default 96000000: cycles from accepted press to long-press event (2 s at 48 MHz). Must be ≥1.
- `REBOOT_ON_LONG`, default 1: 1 means a long press latches `reboot_req_n` low.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_in`  in  1  raw asynchronous button pad.
- `pressed`  out  1  debounced level; 1 while held.
- `press_pulse`  out  1  one cycle on accepted press.
- `release_pulse`  out  1  one cycle on accepted release.
- `click_pulse`  out  1  one cycle on a release that occurs before the long-press event.
- `long_pulse`  out  1  one cycle when hold time reaches `LONG_CYCLES`; at most once per press.
- `reboot_req_n`  out  1  active-low latched reboot request.

## Operation
- Synchroniser: two flops on `btn_in`, both reset to the inactive raw level (`ACTIVE_LOW`). Normalised level: `act = sync2 ^ ACTIVE_LOW`.
- Debounce counter, width `$clog2(DEBOUNCE_CYCLES+1)`:
  - It clears on any cycle where `act == pressed`.
  - It increments on any cycle where `act != pressed`.
  - On the edge where it would reach `DEBOUNCE_CYCLES`, `pressed` toggles and the counter clears.
  - A shorter excursion is ignored entirely.
- Hold counter, width `$clog2(LONG_CYCLES+1)`:
  - It clears while `pressed`=0.
  - It increments each cycle while in HELD.
  - On the edge where it reaches `LONG_CYCLES`, it fires `long_pulse`. It then stops counting; it does not wrap.
- FSM (registered state):
  - IDLE: `pressed`=0. On accepted press, go to HELD and assert `press_pulse`.
  - HELD: pressed, before long. On hold count reaching `LONG_CYCLES`, go to LONG and assert `long_pulse`. On accepted release, go to IDLE and assert `release_pulse` and `click_pulse`.
  - LONG: pressed, long already fired. On accepted release, go to IDLE and assert `release_pulse` only.
- `reboot_req_n`:
  - If `REBOOT_ON_LONG`=1, it falls on the same edge as `long_pulse`. It stays low (sticky) until `rst`, regardless of release.
  - If `REBOOT_ON_LONG`=0, it is constant 1.
- All outputs are registered; no combinational path from `btn_in`.

## Timing
- Reset values: `pressed`=0, all pulses 0, `reboot_req_n`=1, state IDLE, both counters 0.
- Let edge k be the first edge that samples the new `btn_in` level, with the level stable afterwards:
  - `sync2` updates at k+1.
  - `pressed`, `press_pulse` or `release_pulse`, and `click_pulse` (where applicable) update at edge k+1+`DEBOUNCE_CYCLES`.
- Let edge p be the edge where `pressed` rises: `long_pulse` asserts at edge p+`LONG_CYCLES`, provided no accepted release has occurred first.
- Release accepted on the same edge the hold count would reach `LONG_CYCLES`: release wins. This produces `click_pulse`, with no `long_pulse` and no reboot request.
- Every pulse is high for exactly one cycle. Pulses never overlap, except `release_pulse` with `click_pulse`.
- `rst` mid-press: all state returns to reset values. If the button is still held after reset, it is re-accepted as a fresh press after synchroniser plus `DEBOUNCE_CYCLES` delay, and the long timer restarts from 0.
- `rst` has priority over all events on the same edge.

## Test plan
Bench parameters unless noted: `ACTIVE_LOW`=1, `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20.
- Reset with `btn_in`=1 held for 10 cycles: `pressed`=0, all pulses 0, `reboot_req_n`=1 throughout.
- `btn_in` 1→0 first sampled at edge k, held 12 cycles, then 0→1 sampled at edge j:
  - `pressed` rises and `press_pulse`=1 for one cycle at k+5.
  - `release_pulse` and `click_pulse` fire for one cycle at j+5.
  - `long_pulse` never fires.
- Bounce: `btn_in` alternates 3 cycles low / 3 cycles high for 60 cycles → `pressed` stays 0 and no pulse fires.
- Hold low for 40 cycles:
  - `long_pulse` fires for one cycle at p+20.
  - `reboot_req_n` falls on that same edge.
  - On release: `release_pulse` only, no `click_pulse`; `reboot_req_n` stays 0 until `rst`.
- Assert `rst` for 1 cycle at p+10 while the button stays held:
  - Outputs return to reset values.
  - `pressed` re-rises 6 edges after the `rst` edge; `long_pulse` fires 20 edges after that.
- `REBOOT_ON_LONG`=0, 40-cycle hold: `long_pulse` fires; `reboot_req_n` stays 1.
